branch_predict_pc: RTL and testbench

Fetch-side PC generator with a 16-entry direct-mapped branch target buffer (BTB) and 2-bit saturating direction counters. It consumes branch/jump outcomes resolved in the execute stage of the three-stage pipeline: the taken flag, target, opcode and PC of the resolving instruction. It trains the BTB from those outcomes, raises `flush` on a misprediction and redirects fetch. The block is the consuming end of the branch-condition result path.

---
 rtl/branch_predict_pc.sv | 181 ++++++++++++++++++
 tb/tb_branch_predict_pc.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predict_pc.sv
// branch_predict_pc
//   Fetch-side PC generator backed by a direct-mapped branch target buffer.
//   Each BTB entry holds valid, tag, a 2-bit saturating direction counter and
//   a 32-bit target. Fetch looks up pc_f combinationally. Branch/jump outcomes
//   resolved in execute train the BTB and, on a misprediction, raise flush and
//   redirect fetch on the next edge.
//
// Ports
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   stall             hold pc_f; execute-side inputs are ignored this cycle
//   pc_f              registered fetch address
//   pred_taken_f      BTB hit with counter in a taken state
//   pred_target_f     predicted target, or pc_f+4 when not predicted taken
//   ex_valid          execute stage holds a live instruction
//   ex_opcode, ex_pc  opcode and PC of the execute-stage instruction
//   ex_pred_taken     prediction that travelled down with the instruction
//   ex_pred_target    predicted target that travelled down with it
//   ex_br_taken       resolved direction (always 1 for JAL/JALR)
//   ex_target         resolved target address
//   flush             kill the instruction in fetch (misprediction)
//
// BTB_ENTRIES must be a power of two and at least 2.
module branch_predict_pc #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          BTB_ENTRIES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  output logic [31:0] pc_f,
  output logic        pred_taken_f,
  output logic [31:0] pred_target_f,
  input  logic        ex_valid,
  input  logic [6:0]  ex_opcode,
  input  logic [31:0] ex_pc,
  input  logic        ex_pred_taken,
  input  logic [31:0] ex_pred_target,
  input  logic        ex_br_taken,
  input  logic [31:0] ex_target,
  output logic        flush
);

  localparam int IDX   = $clog2(BTB_ENTRIES);
  localparam int TAG_W = 32 - IDX - 2;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [1:0] CTR_WEAK_TAKEN   = 2'b10;
  localparam logic [1:0] CTR_STRONG_TAKEN = 2'b11;

  function automatic logic [1:0] ctr_inc_sat(input logic [1:0] c);
    return (c == 2'b11) ? 2'b11 : c + 2'b01;
  endfunction

  function automatic logic [1:0] ctr_dec_sat(input logic [1:0] c);
    return (c == 2'b00) ? 2'b00 : c - 2'b01;
  endfunction

  // BTB storage. Valid and counters are control state and are reset; tag and
  // target are only meaningful behind a set valid bit, so they carry no reset.
  logic [BTB_ENTRIES-1:0]      btb_valid;
  logic [BTB_ENTRIES-1:0][1:0] btb_ctr;
  logic [TAG_W-1:0]            btb_tag    [BTB_ENTRIES];
  logic [31:0]                 btb_target [BTB_ENTRIES];

  // ---- fetch: BTB lookup on pc_f (reads the pre-update array) ----
  logic [IDX-1:0]   f_idx;
  logic [TAG_W-1:0] f_tag;
  logic             f_hit;
  logic [31:0]      pc_seq;

  assign f_idx         = pc_f[IDX+1:2];
  assign f_tag         = pc_f[31:IDX+2];
  assign f_hit         = btb_valid[f_idx] & (btb_tag[f_idx] == f_tag);
  assign pc_seq        = pc_f + 32'd4;
  assign pred_taken_f  = f_hit & btb_ctr[f_idx][1];
  assign pred_target_f = pred_taken_f ? btb_target[f_idx] : pc_seq;

  // ---- execute: resolve, mispredict detection and BTB update decode ----
  logic             is_branch;
  logic             is_jal;
  logic             is_jalr;
  logic             resolve;
  logic             mispredict;
  logic [31:0]      redirect_pc;
  logic [IDX-1:0]   ex_idx;
  logic [TAG_W-1:0] ex_tag;
  logic             ex_hit;

  assign is_branch = (ex_opcode == OP_BRANCH);
  assign is_jal    = (ex_opcode == OP_JAL);
  assign is_jalr   = (ex_opcode == OP_JALR);
  assign resolve   = ex_valid & ~stall & (is_branch | is_jal | is_jalr);

  // A taken/taken pair still mispredicts when the carried target was stale.
  assign mispredict = resolve &
                      ((ex_br_taken != ex_pred_taken) |
                       (ex_br_taken & ex_pred_taken & (ex_pred_target != ex_target)));
  assign flush       = mispredict;
  assign redirect_pc = ex_br_taken ? ex_target : (ex_pc + 32'd4);

  assign ex_idx = ex_pc[IDX+1:2];
  assign ex_tag = ex_pc[31:IDX+2];
  assign ex_hit = btb_valid[ex_idx] & (btb_tag[ex_idx] == ex_tag);

  logic       ctr_we;
  logic [1:0] ctr_wdata;
  logic       valid_set;
  logic       data_we;

  // JALR never trains the BTB: its target depends on a register, so a cached
  // target would be wrong as often as right.
  always_comb begin
    ctr_we    = 1'b0;
    ctr_wdata = btb_ctr[ex_idx];
    valid_set = 1'b0;
    data_we   = 1'b0;
    if (resolve) begin
      if (is_branch) begin
        if (ex_hit) begin
          ctr_we    = 1'b1;
          ctr_wdata = ex_br_taken ? ctr_inc_sat(btb_ctr[ex_idx])
                                  : ctr_dec_sat(btb_ctr[ex_idx]);
          data_we   = ex_br_taken;
        end else if (ex_br_taken) begin
          // Cold taken branch evicts whatever occupied the slot.
          ctr_we    = 1'b1;
          ctr_wdata = CTR_WEAK_TAKEN;
          valid_set = 1'b1;
          data_we   = 1'b1;
        end
      end else if (is_jal) begin
        ctr_we    = 1'b1;
        ctr_wdata = CTR_STRONG_TAKEN;
        valid_set = 1'b1;
        data_we   = 1'b1;
      end
    end
  end

  // Next fetch address: a misprediction overrides any fetch-side prediction.
  logic [31:0] pc_next;

  always_comb begin
    pc_next = pc_seq;
    if (mispredict) begin
      pc_next = redirect_pc;
    end else if (stall) begin
      pc_next = pc_f;
    end else if (pred_taken_f) begin
      pc_next = pred_target_f;
    end
  end

  // ---- state update at the clock edge ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_f      <= RESET_PC;
      btb_valid <= '0;
      btb_ctr   <= '0;
    end else begin
      pc_f <= pc_next;
      if (valid_set) begin
        btb_valid[ex_idx] <= 1'b1;
      end
      if (ctr_we) begin
        btb_ctr[ex_idx] <= ctr_wdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (data_we) begin
      btb_tag[ex_idx]    <= ex_tag;
      btb_target[ex_idx] <= ex_target;
    end
  end

endmodule

// File: tb/tb_branch_predict_pc.sv
module tb_branch_predict_pc;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam logic [6:0]  OP_BR   = 7'b1100011;
  localparam logic [6:0]  OP_JAL  = 7'b1101111;
  localparam logic [6:0]  OP_JALR = 7'b1100111;
  localparam logic [6:0]  OP_ADD  = 7'b0110011;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic [31:0] pc_f;
  logic        pred_taken_f;
  logic [31:0] pred_target_f;
  logic        ex_valid;
  logic [6:0]  ex_opcode;
  logic [31:0] ex_pc;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;
  logic        ex_br_taken;
  logic [31:0] ex_target;
  logic        flush;

  int checks = 0;
  int errors = 0;

  branch_predict_pc #(.RESET_PC(RST_PC), .BTB_ENTRIES(16)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .pc_f(pc_f), .pred_taken_f(pred_taken_f), .pred_target_f(pred_target_f),
    .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_pc(ex_pc),
    .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
    .ex_br_taken(ex_br_taken), .ex_target(ex_target), .flush(flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a table of 16 entries addressed by word number mod 16.
  bit          m_valid [16];
  int          m_ctr   [16];
  logic [31:0] m_tag   [16];
  logic [31:0] m_tgt   [16];
  logic [31:0] m_pc;

  function automatic int midx(input logic [31:0] a);
    return int'((a >> 2) % 32'd16);
  endfunction

  function automatic bit m_hit(input logic [31:0] a);
    return m_valid[midx(a)] && (m_tag[midx(a)] == (a >> 6));
  endfunction

  function automatic bit m_pred(input logic [31:0] a);
    return m_hit(a) && (m_ctr[midx(a)] >= 2);
  endfunction

  function automatic logic [31:0] m_ptgt(input logic [31:0] a);
    return m_pred(a) ? m_tgt[midx(a)] : a + 32'd4;
  endfunction

  function automatic bit m_resolve();
    return ex_valid && !stall &&
           (ex_opcode == OP_BR || ex_opcode == OP_JAL || ex_opcode == OP_JALR);
  endfunction

  function automatic bit m_mispred();
    return m_resolve() &&
           ((ex_br_taken != ex_pred_taken) ||
            (ex_br_taken && ex_pred_taken && ex_pred_target != ex_target));
  endfunction

  function automatic logic [31:0] m_next_pc();
    if (m_mispred()) return ex_br_taken ? ex_target : ex_pc + 32'd4;
    if (stall) return m_pc;
    return m_ptgt(m_pc);
  endfunction

  function automatic int m_train(input int c, input bit taken);
    if (taken) return (c < 3) ? c + 1 : 3;
    return (c > 0) ? c - 1 : 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc <= RST_PC;
      for (int i = 0; i < 16; i++) begin
        m_valid[i] <= 1'b0;
        m_ctr[i]   <= 0;
      end
    end else begin
      m_pc <= m_next_pc();
      if (m_resolve()) begin
        if (ex_opcode == OP_BR) begin
          if (m_hit(ex_pc)) begin
            m_ctr[midx(ex_pc)] <= m_train(m_ctr[midx(ex_pc)], ex_br_taken);
            if (ex_br_taken) m_tgt[midx(ex_pc)] <= ex_target;
          end else if (ex_br_taken) begin
            m_valid[midx(ex_pc)] <= 1'b1;
            m_tag[midx(ex_pc)]   <= ex_pc >> 6;
            m_ctr[midx(ex_pc)]   <= 2;
            m_tgt[midx(ex_pc)]   <= ex_target;
          end
        end else if (ex_opcode == OP_JAL) begin
          m_valid[midx(ex_pc)] <= 1'b1;
          m_tag[midx(ex_pc)]   <= ex_pc >> 6;
          m_ctr[midx(ex_pc)]   <= 3;
          m_tgt[midx(ex_pc)]   <= ex_target;
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      check("cmp_pc", pc_f, m_pc);
      check("cmp_pred_taken", {31'b0, pred_taken_f}, {31'b0, m_pred(m_pc)});
      check("cmp_pred_target", pred_target_f, m_ptgt(m_pc));
      check("cmp_flush", {31'b0, flush}, {31'b0, m_mispred()});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one execute-stage instruction for a cycle; check flush mid-cycle
  // and, optionally, the fetch address after the edge.
  task automatic resolve(input string name, input logic [6:0] op, input logic [31:0] pc,
                         input logic ptk, input logic [31:0] ptgt,
                         input logic tk, input logic [31:0] tgt,
                         input logic exp_fl, input logic chk_pc, input logic [31:0] exp_pc);
    ex_valid       = 1'b1;
    ex_opcode      = op;
    ex_pc          = pc;
    ex_pred_taken  = ptk;
    ex_pred_target = ptgt;
    ex_br_taken    = tk;
    ex_target      = tgt;
    @(negedge clk);
    check({name, "_flush"}, {31'b0, flush}, {31'b0, exp_fl});
    tick();
    ex_valid = 1'b0;
    if (chk_pc) check({name, "_pc"}, pc_f, exp_pc);
  endtask

  // Point fetch at an address with a JALR, which never trains the BTB.
  task automatic steer(input logic [31:0] addr);
    resolve("steer", OP_JALR, 32'h30, 1'b0, 32'h34, 1'b1, addr, 1'b1, 1'b1, addr);
  endtask

  task automatic pred_is(input string name, input logic exp_tk, input logic [31:0] exp_tgt);
    check({name, "_taken"}, {31'b0, pred_taken_f}, {31'b0, exp_tk});
    check({name, "_target"}, pred_target_f, exp_tgt);
  endtask

  initial begin
    rst_n = 1'b1; stall = 1'b0; ex_valid = 1'b0; ex_opcode = 7'b0;
    ex_pc = '0; ex_pred_taken = 1'b0; ex_pred_target = '0;
    ex_br_taken = 1'b0; ex_target = '0;
    #2 rst_n = 1'b0;

    // reset state
    @(negedge clk);
    check("rst_pc", pc_f, 32'h100);
    pred_is("rst_pred", 1'b0, 32'h104);
    check("rst_flush", {31'b0, flush}, 32'h0);
    tick();
    rst_n = 1'b1;
    check("rst_hold_pc", pc_f, 32'h100);
    tick(); check("post_rst_pc1", pc_f, 32'h104);
    tick(); check("post_rst_pc2", pc_f, 32'h108);

    // cold taken branch allocates entry 4
    resolve("cold_br", OP_BR, 32'h10, 1'b0, 32'h14, 1'b1, 32'h40, 1'b1, 1'b1, 32'h40);
    steer(32'h10);
    pred_is("cold_br_pred", 1'b1, 32'h40);
    // mispredict beats a predicted-taken fetch
    resolve("mp_wins", OP_JALR, 32'h30, 1'b0, 32'h34, 1'b1, 32'h30, 1'b1, 1'b1, 32'h30);

    // counter saturation: three taken, then not-taken twice
    for (int i = 0; i < 3; i++)
      resolve("sat_tk", OP_BR, 32'h10, 1'b1, 32'h40, 1'b1, 32'h40, 1'b0, 1'b0, 32'h0);
    resolve("nt1", OP_BR, 32'h10, 1'b1, 32'h40, 1'b0, 32'h40, 1'b1, 1'b1, 32'h14);
    steer(32'h10);
    pred_is("nt1_pred", 1'b1, 32'h40);
    resolve("nt2", OP_BR, 32'h10, 1'b1, 32'h40, 1'b0, 32'h40, 1'b1, 1'b1, 32'h14);
    steer(32'h10);
    pred_is("nt2_pred", 1'b0, 32'h14);

    // JAL allocates entry 8; a JALR at the same PC leaves it alone
    resolve("jal", OP_JAL, 32'h20, 1'b0, 32'h24, 1'b1, 32'h60, 1'b1, 1'b1, 32'h60);
    resolve("jalr", OP_JALR, 32'h20, 1'b1, 32'h60, 1'b1, 32'h80, 1'b1, 1'b1, 32'h80);
    steer(32'h20);
    pred_is("jalr_nowrite", 1'b1, 32'h60);

    // target mismatch on a hit-predicted JAL rewrites the target
    resolve("tgt_mm", OP_JAL, 32'h20, 1'b1, 32'h60, 1'b1, 32'h70, 1'b1, 1'b1, 32'h70);
    steer(32'h20);
    pred_is("tgt_mm_pred", 1'b1, 32'h70);
    // correctly predicted taken fetch: zero bubbles
    resolve("jal_ok", OP_JAL, 32'h20, 1'b1, 32'h70, 1'b1, 32'h70, 1'b0, 1'b1, 32'h70);

    // stall masks a mispredicting resolve
    stall = 1'b1;
    resolve("stall", OP_BR, 32'h58, 1'b0, 32'h5C, 1'b1, 32'h90, 1'b0, 1'b1, 32'h70);
    stall = 1'b0;
    steer(32'h58);
    pred_is("stall_noupd", 1'b0, 32'h5C);
    resolve("re_present", OP_BR, 32'h58, 1'b0, 32'h5C, 1'b1, 32'h90, 1'b1, 1'b1, 32'h90);
    steer(32'h58);
    pred_is("re_present_pred", 1'b1, 32'h90);

    // non-control opcode neither flushes nor trains
    resolve("add", OP_ADD, 32'h10, 1'b0, 32'h14, 1'b1, 32'h200, 1'b0, 1'b0, 32'h0);
    steer(32'h10);
    pred_is("add_nowrite", 1'b0, 32'h14);

    // PC wrap
    steer(32'hFFFF_FFFC);
    pred_is("wrap_pred", 1'b0, 32'h0);
    tick();
    check("wrap_pc", pc_f, 32'h0);

    // asynchronous reset mid-run clears everything
    steer(32'h20);
    pred_is("pre_rst_pred", 1'b1, 32'h70);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_pc", pc_f, 32'h100);
    check("mid_rst_pred", {31'b0, pred_taken_f}, 32'h0);
    tick();
    rst_n = 1'b1;
    tick(); check("mid_rst_pc1", pc_f, 32'h104);
    tick(); check("mid_rst_pc2", pc_f, 32'h108);
    steer(32'h20);
    pred_is("mid_rst_cleared", 1'b0, 32'h24);

    repeat (2) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
